// File: rtl/decoder_3to8_seq.sv
// decoder_3to8_seq
//   Sequential 3-to-8 decoder. It is the counterpart of the 8-to-3 priority
//   encoder. It takes an encoded index and the encoder's invalid flag over a
//   valid/ready handshake. It drives a registered one-hot line that stays
//   asserted for HOLD_CYCLES cycles. A single-entry pending buffer holds the
//   next code, so back-to-back codes are not lost. Accepted invalid codes are
//   counted in a saturating counter for debug.
//
// Parameters
//   HOLD_CYCLES : cycles each one-hot output stays asserted (1..255)
//   ERR_W       : width of the saturating invalid-code counter
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : encoded code present
//   in_ready   : block can accept a code this cycle (combinational)
//   in_idx     : encoded index (3 bits)
//   in_invalid : encoder invalid flag; in_idx is ignored when set
//   out_onehot : decoded one-hot line
//   out_valid  : out_onehot is meaningful
//   busy       : holding an output or pending buffer occupied
//   err_count  : saturating count of accepted invalid codes
module decoder_3to8_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_idx,
  input  logic             in_invalid,
  output logic [7:0]       out_onehot,
  output logic             out_valid,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [7:0]       onehot_nxt;
  logic             out_valid_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [2:0]       pend_idx, pend_idx_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             accept;
  logic             acc_code;

  function automatic logic [7:0] dec(input logic [2:0] i);
    dec = 8'b0000_0001 << i;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_onehot <= onehot_nxt;
      out_valid  <= out_valid_nxt;
      pend_valid <= pend_valid_nxt;
      pend_idx   <= pend_idx_nxt;
      err_count  <= err_nxt;
    end
  end

  always_comb begin
    in_ready       = (state == IDLE) | ~pend_valid;
    accept         = in_valid & in_ready;
    acc_code       = accept & ~in_invalid;

    state_nxt      = state;
    cnt_nxt        = cnt;
    onehot_nxt     = out_onehot;
    out_valid_nxt  = out_valid;
    pend_valid_nxt = pend_valid;
    pend_idx_nxt   = pend_idx;
    err_nxt        = err_count;

    // Invalid codes only count; they never touch state or outputs.
    if (accept && in_invalid && (err_count != '1))
      err_nxt = err_count + ERR_W'(1);

    unique case (state)
      IDLE: begin
        if (acc_code) begin
          state_nxt     = HOLD;
          onehot_nxt    = dec(in_idx);
          out_valid_nxt = 1'b1;
          cnt_nxt       = RELOAD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 8'd1;
          // in_ready here implies the pending slot is empty.
          if (acc_code) begin
            pend_valid_nxt = 1'b1;
            pend_idx_nxt   = in_idx;
          end
        end else if (pend_valid) begin
          onehot_nxt     = dec(pend_idx);
          cnt_nxt        = RELOAD;
          pend_valid_nxt = 1'b0;
        end else if (acc_code) begin
          // A code arriving on the expiry edge bypasses the pending slot,
          // so out_valid has no gap.
          onehot_nxt = dec(in_idx);
          cnt_nxt    = RELOAD;
        end else begin
          state_nxt     = IDLE;
          onehot_nxt    = '0;
          out_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == HOLD) | pend_valid;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
module tb_decoder_3to8_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a: HOLD_CYCLES=4, ERR_W=8
  logic       a_valid = 1'b0, a_ready, a_invalid = 1'b0, a_ovalid, a_busy;
  logic [2:0] a_idx = '0;
  logic [7:0] a_onehot, a_err;
  // Instance b: HOLD_CYCLES=4, ERR_W=3
  logic       b_valid = 1'b0, b_ready, b_invalid = 1'b0, b_ovalid, b_busy;
  logic [2:0] b_idx = '0;
  logic [7:0] b_onehot;
  logic [2:0] b_err;
  // Instance c: HOLD_CYCLES=1, ERR_W=8
  logic       c_valid = 1'b0, c_ready, c_invalid = 1'b0, c_ovalid, c_busy;
  logic [2:0] c_idx = '0;
  logic [7:0] c_onehot, c_err;

  int vectors = 0;
  int miscompares = 0;

  decoder_3to8_seq #(.HOLD_CYCLES(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_idx(a_idx), .in_invalid(a_invalid), .out_onehot(a_onehot),
    .out_valid(a_ovalid), .busy(a_busy), .err_count(a_err));

  decoder_3to8_seq #(.HOLD_CYCLES(4), .ERR_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_idx(b_idx), .in_invalid(b_invalid), .out_onehot(b_onehot),
    .out_valid(b_ovalid), .busy(b_busy), .err_count(b_err));

  decoder_3to8_seq #(.HOLD_CYCLES(1), .ERR_W(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready),
    .in_idx(c_idx), .in_invalid(c_invalid), .out_onehot(c_onehot),
    .out_valid(c_ovalid), .busy(c_busy), .err_count(c_err));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (a_onehot !== 8'h00 || a_ovalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: onehot=%b valid=%b, want 00000000/0", a_onehot, a_ovalid);
    end
    #9 rst = 1'b0;
    step();
    step();
    vectors++;
    if (a_onehot !== 8'h00 || a_ovalid !== 1'b0 || a_err !== 8'd0 || a_ready !== 1'b1 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: onehot=%b valid=%b err=%0d ready=%b busy=%b, want 00000000/0/0/1/0",
               a_onehot, a_ovalid, a_err, a_ready, a_busy);
    end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_idx = 3'd5; a_invalid = 1'b0;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (a_onehot !== 8'b0010_0000 || a_ovalid !== 1'b1 || a_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL single_hold[%0d]: onehot=%b valid=%b busy=%b, want 00100000/1/1", k, a_onehot, a_ovalid, a_busy);
      end
      step();
    end
    vectors++;
    if (a_onehot !== 8'h00 || a_ovalid !== 1'b0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: onehot=%b valid=%b busy=%b, want 00000000/0/0", a_onehot, a_ovalid, a_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] codes [3];
    logic [7:0] out_exp [13];
    logic       rdy_exp [13];
    int         ci;
    logic       acc;
    codes = '{3'd3, 3'd6, 3'd1};
    out_exp = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h40, 8'h40, 8'h40, 8'h40,
                8'h02, 8'h02, 8'h02, 8'h02, 8'h00};
    rdy_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ci = 0;
    a_valid = 1'b1; a_idx = codes[0]; a_invalid = 1'b0;
    for (int k = 0; k < 13; k++) begin
      acc = a_valid & a_ready;
      step();
      if (acc) begin
        ci++;
        if (ci < 3) a_idx = codes[ci];
        else a_valid = 1'b0;
      end
      vectors++;
      if (a_onehot !== out_exp[k] || a_ovalid !== (k < 12) || a_ready !== rdy_exp[k]) begin
        miscompares++;
        $display("FAIL b2b[%0d]: onehot=%b valid=%b ready=%b, want %b/%b/%b",
                 k, a_onehot, a_ovalid, a_ready, out_exp[k], (k < 12), rdy_exp[k]);
      end
    end
    vectors++;
    if (ci != 3) begin
      miscompares++;
      $display("FAIL b2b_accepts: accepted=%0d, want 3", ci);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_idx = 3'(i); a_invalid = 1'b0;
      step();
      a_valid = 1'b0;
      vectors++;
      if (a_onehot !== exp_tab[i] || a_ovalid !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep[%0d]: onehot=%b valid=%b, want %b/1", i, a_onehot, a_ovalid, exp_tab[i]);
      end
      repeat (4) step();
    end
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_idx = 3'(i + 2); a_invalid = 1'b1;
      step();
      vectors++;
      if (a_onehot !== 8'h00 || a_ovalid !== 1'b0 || a_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_inv[%0d]: onehot=%b valid=%b busy=%b, want 00000000/0/0", i, a_onehot, a_ovalid, a_busy);
      end
    end
    a_valid = 1'b0; a_invalid = 1'b0;
    vectors++;
    if (a_err !== 8'd5) begin
      miscompares++;
      $display("FAIL sweep_err: err_count=%0d, want 5", a_err);
    end
    // Invalid code during HOLD: counted, never buffered.
    a_valid = 1'b1; a_idx = 3'd4;
    step();
    a_idx = 3'd7; a_invalid = 1'b1;
    step();
    a_valid = 1'b0; a_invalid = 1'b0;
    vectors++;
    if (a_onehot !== 8'h10 || a_err !== 8'd6 || a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_inv: onehot=%b err=%0d ready=%b, want 00010000/6/1", a_onehot, a_err, a_ready);
    end
    repeat (3) step();
    vectors++;
    if (a_onehot !== 8'h00 || a_ovalid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_inv_end: onehot=%b valid=%b, want 00000000/0", a_onehot, a_ovalid);
    end
  endtask

  task automatic test_err_saturate();
    logic [2:0] exp_tab [9];
    exp_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    b_valid = 1'b1; b_invalid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b_idx = 3'(i);
      step();
      vectors++;
      if (b_err !== exp_tab[i] || b_ovalid !== 1'b0) begin
        miscompares++;
        $display("FAIL err_sat[%0d]: err=%0d valid=%b, want %0d/0", i, b_err, b_ovalid, exp_tab[i]);
      end
    end
    b_valid = 1'b0; b_invalid = 1'b0;
  endtask

  task automatic test_async_reset();
    a_valid = 1'b1; a_idx = 3'd3; a_invalid = 1'b0;
    step();
    a_idx = 3'd5;
    step();
    a_valid = 1'b0;
    vectors++;
    if (a_onehot !== 8'h08 || a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_pre: onehot=%b ready=%b, want 00001000/0", a_onehot, a_ready);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (a_onehot !== 8'h00 || a_ovalid !== 1'b0 || a_busy !== 1'b0 || a_err !== 8'd0) begin
      miscompares++;
      $display("FAIL areset_now: onehot=%b valid=%b busy=%b err=%0d, want 00000000/0/0/0",
               a_onehot, a_ovalid, a_busy, a_err);
    end
    #1 rst = 1'b0;
    step();
    a_valid = 1'b1; a_idx = 3'd2;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (a_onehot !== ((k < 4) ? 8'h04 : 8'h00)) begin
        miscompares++;
        $display("FAIL areset_after[%0d]: onehot=%b, want %b", k, a_onehot, ((k < 4) ? 8'h04 : 8'h00));
      end
      step();
    end
  endtask

  task automatic test_hold1_stream();
    logic [2:0] codes [4];
    logic [7:0] exp_tab [4];
    codes = '{3'd0, 3'd7, 3'd0, 3'd7};
    exp_tab = '{8'h01, 8'h80, 8'h01, 8'h80};
    c_valid = 1'b1; c_invalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c_idx = codes[k];
      vectors++;
      if (c_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL h1_ready[%0d]: ready=%b, want 1", k, c_ready);
      end
      step();
      vectors++;
      if (c_onehot !== exp_tab[k] || c_ovalid !== 1'b1) begin
        miscompares++;
        $display("FAIL h1_out[%0d]: onehot=%b valid=%b, want %b/1", k, c_onehot, c_ovalid, exp_tab[k]);
      end
    end
    c_valid = 1'b0;
    step();
    vectors++;
    if (c_onehot !== 8'h00 || c_ovalid !== 1'b0 || c_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL h1_end: onehot=%b valid=%b busy=%b, want 00000000/0/0", c_onehot, c_ovalid, c_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sweep();
    test_err_saturate();
    test_async_reset();
    test_hold1_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_seq.md
Name: decoder_3to8_seq

Overview:
- Sequential 3-to-8 decoder; the inverse of the team's 8-to-3 priority encoder.
- Accepts an encoded index plus the encoder's invalid flag over a valid/ready handshake.
- Drives a registered one-hot line that holds for a programmable number of cycles.
- Has a 1-entry pending buffer so back-to-back codes are not lost, and counts invalid codes for debug.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot output stays asserted. Legal range is 1..255.
- ERR_W, 8, width of the saturating invalid-code counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, encoded code present.
- in_ready, output, 1, block can accept a code this cycle.
- in_idx, input, 3, encoded index. Same encoding as the encoder output o.
- in_invalid, input, 1, encoder invalid flag. When 1, in_idx is ignored.
- out_onehot, output, 8, decoded one-hot line.
- out_valid, output, 1, out_onehot is meaningful.
- busy, output, 1, state is HOLD or the pending buffer is occupied.
- err_count, output, ERR_W, saturating count of accepted invalid codes.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, out_onehot=0, out_valid=0, hold counter=0.
  - pend_valid=0, pend_idx=0, err_count=0.
  - in_ready=1 while rst=1 is don't-care; no transfer is accepted while rst=1.
  - Reset mid-HOLD drops both the active and the pending code.
- Accept: a transfer occurs on a rising edge when in_valid=1 and in_ready=1.
- in_ready is combinational: 1 in IDLE; in HOLD it equals !pend_valid.
- Invalid code (in_invalid=1) accepted in any state:
  - err_count increments and saturates at 2^ERR_W-1.
  - Nothing is decoded or buffered; state and outputs are unchanged.
- IDLE, valid code accepted at edge N:
  - out_onehot = 1<<in_idx and out_valid=1, visible after edge N (1-cycle latency).
  - hold counter = HOLD_CYCLES-1; state goes to HOLD.
- HOLD:
  - Each edge with counter>0 decrements the counter; outputs are held.
  - A valid code accepted while pend_valid=0 is stored in pend_idx with pend_valid=1.
  - Only the pending path consumes input here; the active output is never overwritten.
- HOLD expiry (counter==0 at an edge), pend_valid=1:
  - Load out_onehot = 1<<pend_idx and reload counter = HOLD_CYCLES-1.
  - Clear pend_valid and stay in HOLD. out_valid stays 1 with no gap cycle.
- HOLD expiry, pend_valid=0: out_onehot=0, out_valid=0, state goes to IDLE.
- Simultaneous expiry and accept (pend_valid=0, in_ready=1):
  - The incoming valid code goes straight to the output: load it, reload the counter, stay in HOLD, pend stays 0.
  - An incoming invalid code on that edge only counts; the block goes to IDLE.
- HOLD_CYCLES=1: each code is shown for exactly one cycle; back-to-back codes produce a continuous out_valid.
- Invariants:
  - out_onehot has exactly one bit set when out_valid=1 and is 0 otherwise.
  - busy = (state==HOLD) | pend_valid.

Test Plan:
- Reset, then idle with in_valid=0 -> out_onehot=00000000, out_valid=0, err_count=0, in_ready=1.
- HOLD_CYCLES=4; single accept of in_idx=5 at edge N -> out_onehot=00100000 for edges N+1..N+4 (4 cycles), then 0 and out_valid=0.
- Codes 3, 6, 1 offered back-to-back with in_valid held -> 3 accepted; 6 buffered and in_ready=0; 1 stalls until 6 is loaded; outputs 00001000 x4, 01000000 x4, 00000010 x4, out_valid continuous for 12 cycles.
- Sweep in_idx 0..7 with in_invalid=0, plus 5 codes with in_invalid=1 -> each one-hot matches 1<<idx; err_count=5; invalid codes produce no output change. With ERR_W=3, 9 invalid codes -> err_count=7 (saturated).
- Assert rst asynchronously mid-HOLD with a code pending -> outputs 0 immediately, with no clock edge needed; after release a new code 2 -> 00000100; the dropped pending code never appears.
- HOLD_CYCLES=1, codes 0,7,0,7 streamed -> in_ready stays 1 throughout; out_onehot alternates 00000001/10000000 each cycle; out_valid high for 4 consecutive cycles.
